// File: rtl/song_player.sv
// song_player: steps through an external note ROM for the selected song and
// presents one note code at a time to the buzzer tone generator.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active low
//   song_num   selected song 0..2; 3 plays nothing
//   pause      level; 1 freezes playback and mutes the output
//   rom_addr   {song, idx} to the note ROM (registered)
//   rom_data   ROM word: [7:3] note code, [2:0] duration-1
//   note       note code to the tone generator; 0 is silent
//   note_valid 1 while a pitched note (code 1..21) sounds
//   note_idx   index of the current note within the song
//   playing    1 while actively fetching/playing and not paused
//   song_done  one-cycle pulse at the end of a song
module song_player #(
    parameter int unsigned TICKS_PER_UNIT = 12_500_000,
    parameter int unsigned GAP_TICKS      = 1_000_000,
    parameter int unsigned SONG_LEN       = 64,
    parameter bit          LOOP           = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] song_num,
    input  logic       pause,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [4:0] note,
    output logic       note_valid,
    output logic [5:0] note_idx,
    output logic       playing,
    output logic       song_done
);

    localparam int unsigned TickW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int unsigned GapW  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_UNIT - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
    localparam logic [5:0]       IdxLast  = 6'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StPlay,
        StGap,
        StEnd,
        StDone
    } state_e;

    state_e           state_q;
    logic [1:0]       song_q;
    logic [5:0]       idx_q;
    logic [TickW-1:0] tick_q;
    logic [2:0]       unit_q;
    logic [GapW-1:0]  gap_q;
    logic [4:0]       code_q;
    logic [2:0]       dur_q;
    // Set once the ROM has had a full cycle to register the new address.
    logic             rom_wait_q;

    logic [4:0] rom_code;
    logic [2:0] rom_dur;
    logic       rom_is_end;
    logic       rom_pitched;
    logic       code_pitched;
    logic       last_idx;

    assign rom_code     = rom_data[7:3];
    assign rom_dur      = rom_data[2:0];
    // Codes 22..31 are unused or the end marker; all terminate the song.
    assign rom_is_end   = (rom_code >= 5'd22);
    assign rom_pitched  = (rom_code != 5'd0) && (rom_code <= 5'd21);
    assign code_pitched = (code_q != 5'd0) && (code_q <= 5'd21);
    assign last_idx     = (idx_q == IdxLast);
    assign note_idx     = idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            song_q     <= song_num;
            idx_q      <= 6'd0;
            tick_q     <= '0;
            unit_q     <= 3'd0;
            gap_q      <= '0;
            code_q     <= 5'd0;
            dur_q      <= 3'd0;
            rom_wait_q <= 1'b0;
            rom_addr   <= {song_num, 6'd0};
            note       <= 5'd0;
            note_valid <= 1'b0;
            playing    <= 1'b0;
            song_done  <= 1'b0;
        end else if (song_num != song_q) begin
            // Song change outranks pause and every state; rom_addr is left
            // alone until the next FETCH.
            song_q     <= song_num;
            idx_q      <= 6'd0;
            tick_q     <= '0;
            unit_q     <= 3'd0;
            gap_q      <= '0;
            rom_wait_q <= 1'b0;
            note       <= 5'd0;
            note_valid <= 1'b0;
            song_done  <= 1'b0;
            if (song_num == 2'd3) begin
                state_q <= StIdle;
                playing <= 1'b0;
            end else begin
                state_q <= StFetch;
                playing <= ~pause;
            end
        end else if (song_q == 2'd3) begin
            state_q    <= StIdle;
            note       <= 5'd0;
            note_valid <= 1'b0;
            playing    <= 1'b0;
            song_done  <= 1'b0;
        end else if (pause) begin
            // Everything but the outputs holds, so the remaining time is kept.
            note       <= 5'd0;
            note_valid <= 1'b0;
            playing    <= 1'b0;
            song_done  <= 1'b0;
        end else begin
            song_done  <= 1'b0;
            playing    <= 1'b1;
            note       <= 5'd0;
            note_valid <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    rom_addr   <= {song_q, idx_q};
                    rom_wait_q <= 1'b0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (!rom_wait_q) begin
                        rom_wait_q <= 1'b1;
                    end else begin
                        code_q <= rom_code;
                        dur_q  <= rom_dur;
                        tick_q <= '0;
                        unit_q <= 3'd0;
                        if (rom_is_end) begin
                            state_q   <= StEnd;
                            song_done <= 1'b1;
                            playing   <= 1'b0;
                        end else begin
                            state_q    <= StPlay;
                            note       <= rom_code;
                            note_valid <= rom_pitched;
                        end
                    end
                end
                StPlay: begin
                    note       <= code_q;
                    note_valid <= code_pitched;
                    // Two nested counters give (dur+1)*TICKS_PER_UNIT cycles.
                    if (tick_q == TickLast) begin
                        tick_q <= '0;
                        if (unit_q == dur_q) begin
                            unit_q     <= 3'd0;
                            note       <= 5'd0;
                            note_valid <= 1'b0;
                            if (GAP_TICKS != 0) begin
                                gap_q   <= '0;
                                state_q <= StGap;
                            end else if (last_idx) begin
                                state_q   <= StEnd;
                                song_done <= 1'b1;
                                playing   <= 1'b0;
                            end else begin
                                idx_q   <= idx_q + 6'd1;
                                state_q <= StFetch;
                            end
                        end else begin
                            unit_q <= unit_q + 3'd1;
                        end
                    end else begin
                        tick_q <= tick_q + TickW'(1);
                    end
                end
                StGap: begin
                    if (gap_q == GapLast) begin
                        gap_q <= '0;
                        // The last slot ends the song rather than spilling
                        // into the next song's ROM space.
                        if (last_idx) begin
                            state_q   <= StEnd;
                            song_done <= 1'b1;
                            playing   <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 6'd1;
                            state_q <= StFetch;
                        end
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                StEnd: begin
                    idx_q <= 6'd0;
                    if (LOOP) begin
                        state_q <= StFetch;
                    end else begin
                        state_q <= StDone;
                        playing <= 1'b0;
                    end
                end
                StDone: begin
                    playing <= 1'b0;
                end
                StIdle: begin
                    // Only reachable with a valid song after a stray state;
                    // restart the song cleanly.
                    idx_q   <= 6'd0;
                    state_q <= StFetch;
                end
                default: begin
                    state_q <= StFetch;
                end
            endcase
        end
    end

endmodule
